pc_sequencer: RTL
=================

# pc_sequencer

Owns the program counter of the single-cycle CPU and decides each cycle where it goes next. Candidates are:
- the sequential address;
- the redirect target supplied by the next-PC logic on `goto`;
- an interrupt vector;
- the saved return address on `eret`.

It also sequences halt/resume and arbitrates three latched interrupt requests. It sits between the next-PC logic, the controller decode and the instruction memory address port.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `PC_STEP`, 4, byte increment to the sequential instruction.
- `VEC_BASE`, 32'h0000_0100, address of the level-0 handler.
- `VEC_STRIDE`, 32'h0000_0040, byte distance between consecutive level handlers.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `goto`  in  1  next-PC logic requests redirect this cycle.
- `new_addr`  in  32  redirect target, valid when `goto`=1.
- `halt`  in  1  decoded halt/syscall instruction at current PC.
- `go`  in  1  resume request (single-cycle pulse or level) while halted.
- `stall`  in  1  freeze PC and sequencing this cycle.
- `eret`  in  1  decoded return-from-interrupt at current PC.
- `irq`  in  3  interrupt request pulses; `irq[0]` highest priority.
- `pc`  out  32  registered current PC.
- `pc_plus_1`  out  32  combinational `pc + PC_STEP` (sequential next address).
- `epc`  out  32  saved return address.
- `pending`  out  3  latched, unserviced requests.
- `in_isr`  out  1  handler currently executing.
- `int_level`  out  2  index of the level being serviced (0–2).
- `halted`  out  1  sequencer in HALTED state.
- `instr_cnt`  out  32  retired-instruction counter.

## Operation
- States: RUN, HALTED. `in_isr` is an orthogonal flag; there is no nesting.
- `seq_next` = `goto ? new_addr : pc_plus_1`.
- Request latching: every cycle, in any state including during `stall`, `pending <= (pending & ~clr) | irq`. `clr` is the one-hot bit being serviced this cycle. Set wins over clear on the same bit.
- In RUN with `stall`=0, evaluate in priority order; exactly one action per cycle:
  1. `halt`=1: go to HALTED. `pc` holds. `instr_cnt` increments.
  2. `in_isr`=0 and `pending`≠0: take the lowest-index set bit L.
     - `epc <= seq_next`.
     - `pc <= VEC_BASE + L*VEC_STRIDE` (32-bit modulo arithmetic).
     - `in_isr <= 1`, `int_level <= L`, clear pending[L].
     - `instr_cnt` increments; the current instruction retires.
  3. `eret`=1 and `in_isr`=1: `pc <= epc`, `in_isr <= 0`. `instr_cnt` increments.
  4. Otherwise: `pc <= seq_next`. `instr_cnt` increments.
- `eret` with `in_isr`=0 is treated as a plain instruction: `pc <= seq_next`.
- RUN with `stall`=1: `pc`, state, `epc`, `in_isr`, `int_level` and `instr_cnt` hold. Only `pending` updates.
- HALTED:
  - `pc` and `instr_cnt` hold.
  - `go`=1 (and `stall`=0) returns to RUN with `pc <= pc_plus_1`, resuming after the halt instruction.
  - Pending requests are not taken while HALTED; the earliest they can be taken is the first RUN cycle after resume.
- `goto` and `new_addr` are ignored while HALTED or stalled, and when a vector or `eret` is taken.
- All additions wrap modulo 2^32, including `instr_cnt`.

## Timing
- Reset values (cycle after `rst` sampled high):
  - `pc`=`RESET_PC`, state RUN, `halted`=0.
  - `pending`=0, `in_isr`=0, `int_level`=0, `epc`=0, `instr_cnt`=0.
- `rst` overrides every other input, including mid-handler and while halted.
- `pc_plus_1` is combinational from `pc`. All other outputs are registered.
- Interrupt latency:
  - `irq[L]` high in cycle k sets `pending[L]` at edge k.
  - If eligible in cycle k+1, `pc` shows the vector after edge k+1.
  - Minimum is 2 edges from request to vector fetch.
- Redirect latency: `goto` in cycle k gives `pc`=`new_addr` after edge k.
- `halt` and `irq` in the same eligible cycle: halt wins, and the request stays pending.
- `eret` while a request is pending:
  - `eret` takes precedence only when `in_isr`=1; the vector is taken the next RUN cycle, with `epc` = the post-`eret` `seq_next`.
  - Back-to-back service is therefore one handler-return instruction apart.
- `halted` rises the edge after `halt` is accepted and falls the edge `go` is accepted.

## Test plan
- Reset then 3 free-running cycles, no `goto` → `pc` 0x0, 0x4, 0x8, 0xC. `instr_cnt`=3.
- At `pc`=0x10 drive `goto`=1, `new_addr`=0x80 → next `pc`=0x80. With `stall`=1 for 2 cycles, `pc` stays 0x80 and `instr_cnt` is unchanged.
- At `pc`=0x20 pulse `irq`=3'b110 → one cycle later `pc`=0x140 (level 1), `epc`=0x28 (the address after the retiring instruction at 0x24), `pending`=3'b100. Then `eret` → `pc`=0x28. The next cycle takes level 2 → `pc`=0x180, `epc`=0x2C.
- `halt` at `pc`=0x30 with `irq[0]` pulsed the same cycle → `halted`=1, `pc` holds 0x30, `pending[0]`=1. `go` → `pc`=0x34. The next cycle takes the vector → `pc`=0x100, `epc`=0x38.
- `irq[0]` re-pulsed in the exact cycle level 0 is serviced → `pending[0]` remains 1. `eret` with `in_isr`=0 → `pc` advances to `pc_plus_1`.
- `rst` asserted while `in_isr`=1 and `pending`=3'b011 → all outputs return to reset values the following cycle.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// ----------------------------------------------------------------------------
// pc_sequencer_if
// Bundles the control inputs and the observable state of the program-counter
// sequencer so that the CPU front end and the sequencer share one connection.
//
//   slave  modport (sequencer side):
//     inputs : goto, new_addr, halt, go, stall, eret, irq[2:0]
//     outputs: pc, pc_plus_1, epc, pending[2:0], in_isr, int_level[1:0],
//              halted, instr_cnt
//   master modport (next-PC logic / decode / instruction-fetch side):
//     the same signals with the opposite directions
// ----------------------------------------------------------------------------
interface pc_sequencer_if;
  // Requests toward the sequencer
  logic        goto;       // redirect to new_addr this cycle
  logic [31:0] new_addr;   // redirect target
  logic        halt;       // decoded halt/syscall at current pc
  logic        go;         // resume request while halted
  logic        stall;      // freeze pc and sequencing this cycle
  logic        eret;       // decoded return-from-interrupt at current pc
  logic [2:0]  irq;        // interrupt request pulses, bit 0 highest priority

  // State reported by the sequencer
  logic [31:0] pc;         // registered current pc
  logic [31:0] pc_plus_1;  // pc + PC_STEP, combinational
  logic [31:0] epc;        // saved return address
  logic [2:0]  pending;    // latched, unserviced requests
  logic        in_isr;     // a handler is executing
  logic [1:0]  int_level;  // level being serviced
  logic        halted;     // sequencer is in the HALTED state
  logic [31:0] instr_cnt;  // retired-instruction counter

  modport slave (
    input  goto, new_addr, halt, go, stall, eret, irq,
    output pc, pc_plus_1, epc, pending, in_isr, int_level, halted, instr_cnt
  );

  modport master (
    output goto, new_addr, halt, go, stall, eret, irq,
    input  pc, pc_plus_1, epc, pending, in_isr, int_level, halted, instr_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Owns the program counter of the single-cycle CPU. Each cycle it picks the
// next pc from: the sequential address, a goto redirect, an interrupt vector,
// or the saved return address on eret. It also sequences halt/resume and
// arbitrates three latched interrupt requests (bit 0 highest priority).
//
// Ports:
//   clk  - single clock, all state changes on the rising edge
//   rst  - synchronous, active-high reset
//   bus  - pc_sequencer_if.slave: control inputs and reported state
// ----------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] PC_STEP    = 32'h0000_0004,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0040
) (
  input  logic                 clk,
  input  logic                 rst,
  pc_sequencer_if.slave        bus
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic [2:0]  r_pending;
  logic        r_in_isr;
  logic [1:0]  r_int_level;
  logic        r_halted;
  logic [31:0] r_instr_cnt;

  logic [31:0] w_pc_plus_1;
  logic [31:0] w_seq_next;
  logic [31:0] w_vector;
  logic [1:0]  w_level;
  logic [2:0]  w_clr;
  logic        w_take_irq;

  assign w_pc_plus_1 = r_pc + PC_STEP;
  assign w_seq_next  = bus.goto ? bus.new_addr : w_pc_plus_1;
  assign w_vector    = VEC_BASE + VEC_STRIDE * {30'd0, w_level};

  // Pick the lowest-index pending request and decide whether it is taken.
  // A halt in the same cycle wins; an active handler blocks new service.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_level    = 2'd0;
    w_clr      = 3'b000;
    if (r_pending[0])      w_level = 2'd0;
    else if (r_pending[1]) w_level = 2'd1;
    else if (r_pending[2]) w_level = 2'd2;
    w_take_irq = (r_state == ST_RUN) && !bus.stall && !bus.halt &&
                 !r_in_isr && (r_pending != 3'b000);
    if (w_take_irq) w_clr = 3'b001 << w_level;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_PC;
      r_epc       <= 32'd0;
      r_pending   <= 3'b000;
      r_in_isr    <= 1'b0;
      r_int_level <= 2'd0;
      r_halted    <= 1'b0;
      r_instr_cnt <= 32'd0;
    end else begin
      // Requests latch in every state, stalled or not; a new pulse on the
      // bit being serviced survives the clear.
      r_pending <= (r_pending & ~w_clr) | bus.irq;

      unique case (r_state)
        ST_RUN: begin
          if (!bus.stall) begin
            r_instr_cnt <= r_instr_cnt + 32'd1;
            if (bus.halt) begin
              r_state  <= ST_HALTED;
              r_halted <= 1'b1;
            end else if (w_take_irq) begin
              r_epc       <= w_seq_next;
              r_pc        <= w_vector;
              r_in_isr    <= 1'b1;
              r_int_level <= w_level;
            end else if (bus.eret && r_in_isr) begin
              r_pc     <= r_epc;
              r_in_isr <= 1'b0;
            end else begin
              r_pc <= w_seq_next;
            end
          end
        end
        ST_HALTED: begin
          // Resume just past the halt instruction; the counter already
          // counted the halt when it was accepted.
          if (bus.go && !bus.stall) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
            r_pc     <= w_pc_plus_1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.pc        = r_pc;
  assign bus.pc_plus_1 = w_pc_plus_1;
  assign bus.epc       = r_epc;
  assign bus.pending   = r_pending;
  assign bus.in_isr    = r_in_isr;
  assign bus.int_level = r_int_level;
  assign bus.halted    = r_halted;
  assign bus.instr_cnt = r_instr_cnt;

endmodule
